// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StResp} dmem_state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/dmem_byte_merge.sv
// Combinational byte-lane merge: enabled lanes of wdata_i replace the matching lanes of old_i.
module dmem_byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wen_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (wen_i[i]) merged_o[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency word array with byte-enabled writes and write-first reads.
// Optional DMEM_BACK2BACK_EN lets a new request be accepted during the response cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned      Words     = 2 ** DEPTH_LOG2;
  localparam logic [32:0]      SpanBytes = 33'(1) << (DEPTH_LOG2 + 2);
  localparam logic [LAT_W-1:0] LatLoad   = LAT_W'(LATENCY - 1);

  dmem_state_e      state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  logic [3:0]  wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [Words];

  logic                  accept;
  logic                  access;
  logic [32:0]           offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           old_word;
  logic [31:0]           merged;

  assign accept = req_valid & req_ready;
  assign access = (state_q == StWait) && (cnt_q == '0);

  // 33-bit difference: a borrow lands in bit 32 and forces the span compare to fail.
  assign offset   = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign in_range = offset < SpanBytes;
  assign word_idx = offset[DEPTH_LOG2+1:2];
  assign old_word = mem[word_idx];

  dmem_byte_merge u_merge (
    .old_i    (old_word),
    .wdata_i  (wdata_q),
    .wen_i    (wen_q),
    .merged_o (merged)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StWait;
          cnt_d   = LatLoad;
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StResp;
        else             cnt_d   = cnt_q - LAT_W'(1);
      end
      StResp: begin
        state_d = StIdle;
`ifdef DMEM_BACK2BACK_EN
        if (req_valid) begin
          state_d = StWait;
          cnt_d   = LatLoad;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = 1'b0;
    busy       = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StWait: busy      = 1'b1;
      StResp: begin
        resp_valid = 1'b1;
`ifdef DMEM_BACK2BACK_EN
        req_ready  = 1'b1;
`else
        busy       = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Request latch and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= BE_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (access) begin
        rdata_q <= in_range ? merged : '0;
        err_q   <= ~in_range;
      end
    end
  end

  // Array is deliberately not reset; access is never true while rst holds the FSM in idle.
  always_ff @(posedge clk) begin
    if (access && in_range && (wen_q != BE_NONE)) mem[word_idx] <= merged;
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
